// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared types and constants for the multi-cycle sequencer
// Contents: seq_state_e, ls_size_e, mcause codes, NOP_INSN, ls_eff_lo helper.
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH_REQ  = 3'd0,
        FETCH_WAIT = 3'd1,
        EXEC       = 3'd2,
        MEM_REQ    = 3'd3,
        MEM_WAIT   = 3'd4,
        WB         = 3'd5,
        TRAP       = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        LS_B = 2'd0,
        LS_H = 2'd1,
        LS_W = 2'd2
    } ls_size_e;

    localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_IFAULT    = 4'd1;
    localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LFAULT    = 4'd5;
    localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_SFAULT    = 4'd7;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Low address bits after forcing natural alignment (half: a[0]=0, word: a[1:0]=0).
    function automatic logic [1:0] ls_eff_lo(input logic [1:0] size, input logic [1:0] a);
        logic [1:0] r;
        r = a;
        if (size == LS_H) begin
            r = {a[1], 1'b0};
        end else if (size != LS_B) begin
            r = 2'b00;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational byte-lane alignment for loads and stores
// Ports:
//   ls_size, ls_unsigned : access size (0 byte, 1 half, 2 word) and zero-extend flag
//   addr                 : effective low address bits
//   wdata / wdata_lane   : store source / lane-replicated store data
//   be                   : byte enables
//   rdata / rdata_ext    : raw read word / shifted and extended load data
module lsu_align
    import ctrl_pkg::*;
(
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [31:0] rdata_sh;

    always_comb begin
        rdata_sh = rdata >> {addr, 3'b000};
        case (ls_size)
            LS_B: begin
                be         = 4'b0001 << addr;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = ls_unsigned ? {24'h0, rdata_sh[7:0]}
                                         : {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            end
            LS_H: begin
                be         = 4'b0011 << addr;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = ls_unsigned ? {16'h0, rdata_sh[15:0]}
                                         : {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            end
            default: begin
                be         = 4'hF;
                wdata_lane = wdata;
                rdata_ext  = rdata_sh;
            end
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle fetch/exec/mem/writeback sequencer over one memory port
// Optional feature macro: MISALIGN_TRAP_EN (misaligned fetch/load/store traps instead of forced alignment).
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   mem_req/addr/we/be/wdata            : bus request side, held until mem_gnt
//   mem_gnt, mem_rvalid, mem_rdata      : bus accept and response
//   ir, pc                              : latched instruction and its address, to decoder
//   pc_next_dec, rd_we_dec, rd_wd_dec   : decoder results for non-memory instructions
//   ls_valid/we/size/unsigned/addr/wdata: decoder load/store description
//   mtvec                               : trap vector
//   rd_we, rd_wd, retire                : register write strobe/data, completion pulse
//   trap, trap_cause, trap_pc           : trap entry pulse with mcause and faulting pc
module mc_sequencer
    import ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          WAIT_MAX = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [31:0] pc,
    input  logic [31:0] pc_next_dec,
    input  logic        rd_we_dec,
    input  logic [31:0] rd_wd_dec,
    input  logic        ls_valid,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic        ls_unsigned,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [31:0] mtvec,
    output logic        rd_we,
    output logic [31:0] rd_wd,
    output logic        retire,
    output logic        trap,
    output logic [3:0]  trap_cause,
    output logic [31:0] trap_pc
);

    localparam int            TW   = $clog2(WAIT_MAX) + 1;
    localparam logic [TW-1:0] TMAX = TW'(WAIT_MAX - 1);

    seq_state_e    state_q;
    logic [31:0]   pc_q;
    logic [31:0]   ir_q;
    logic [31:0]   data_q;
    logic [TW-1:0] timer_q;
    logic [3:0]    cause_q;

    logic [1:0]  a_lo;
    logic        ls_misalign;
    logic        fetch_misalign;
    logic        timeout;
    logic [3:0]  lsu_be;
    logic [31:0] lsu_wdata;
    logic [31:0] ld_data;

`ifdef MISALIGN_TRAP_EN
    assign a_lo           = ls_addr[1:0];
    assign ls_misalign    = ((ls_size == LS_H) && ls_addr[0]) ||
                            ((ls_size == LS_W) && (ls_addr[1:0] != 2'b00));
    assign fetch_misalign = (pc_q[1:0] != 2'b00);
`else
    assign a_lo           = ls_eff_lo(ls_size, ls_addr[1:0]);
    assign ls_misalign    = 1'b0;
    assign fetch_misalign = 1'b0;
`endif

    // Cycles since the request was first raised; hitting TMAX without rvalid is a bus error.
    assign timeout = (timer_q == TMAX);

    lsu_align u_lsu_align (
        .ls_size     (ls_size),
        .ls_unsigned (ls_unsigned),
        .addr        (a_lo),
        .wdata       (ls_wdata),
        .rdata       (data_q),
        .be          (lsu_be),
        .wdata_lane  (lsu_wdata),
        .rdata_ext   (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_REQ;
            pc_q    <= RESET_PC;
            ir_q    <= NOP_INSN;
            data_q  <= 32'h0;
            timer_q <= '0;
            cause_q <= 4'h0;
        end else begin
            case (state_q)
                FETCH_REQ: begin
                    if (fetch_misalign) begin
                        cause_q <= CAUSE_IMISALIGN;
                        state_q <= TRAP;
                    end else if (timeout) begin
                        cause_q <= CAUSE_IFAULT;
                        state_q <= TRAP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        if (mem_gnt) state_q <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (mem_rvalid) begin
                        ir_q    <= mem_rdata;
                        state_q <= EXEC;
                    end else if (timeout) begin
                        cause_q <= CAUSE_IFAULT;
                        state_q <= TRAP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                EXEC: begin
                    timer_q <= '0;
                    if (ls_valid) begin
                        if (ls_misalign) begin
                            cause_q <= ls_we ? CAUSE_SMISALIGN : CAUSE_LMISALIGN;
                            state_q <= TRAP;
                        end else begin
                            state_q <= MEM_REQ;
                        end
                    end else begin
                        pc_q    <= pc_next_dec;
                        state_q <= FETCH_REQ;
                    end
                end
                MEM_REQ: begin
                    if (timeout) begin
                        cause_q <= ls_we ? CAUSE_SFAULT : CAUSE_LFAULT;
                        state_q <= TRAP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                        if (mem_gnt) state_q <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_rvalid) begin
                        if (ls_we) begin
                            pc_q    <= pc_next_dec;
                            timer_q <= '0;
                            state_q <= FETCH_REQ;
                        end else begin
                            data_q  <= mem_rdata;
                            state_q <= WB;
                        end
                    end else if (timeout) begin
                        cause_q <= ls_we ? CAUSE_SFAULT : CAUSE_LFAULT;
                        state_q <= TRAP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                WB: begin
                    pc_q    <= pc_next_dec;
                    timer_q <= '0;
                    state_q <= FETCH_REQ;
                end
                TRAP: begin
                    pc_q    <= mtvec;
                    timer_q <= '0;
                    state_q <= FETCH_REQ;
                end
                default: begin
                    timer_q <= '0;
                    state_q <= FETCH_REQ;
                end
            endcase
        end
    end

    // Reset state is FETCH_REQ, so the request is masked while reset is held.
    assign mem_req    = ~reset & (((state_q == FETCH_REQ) & ~fetch_misalign) | (state_q == MEM_REQ));
    assign mem_addr   = (state_q == MEM_REQ) ? {ls_addr[31:2], 2'b00} : {pc_q[31:2], 2'b00};
    assign mem_we     = (state_q == MEM_REQ) & ls_we;
    assign mem_be     = (state_q == MEM_REQ) ? lsu_be : 4'hF;
    assign mem_wdata  = lsu_wdata;

    assign ir         = ir_q;
    assign pc         = pc_q;

    assign retire     = ((state_q == EXEC) & ~ls_valid) |
                        ((state_q == MEM_WAIT) & mem_rvalid & ls_we) |
                        (state_q == WB);
    assign rd_we      = ((state_q == EXEC) & ~ls_valid & rd_we_dec) | (state_q == WB);
    assign rd_wd      = (state_q == WB) ? ld_data : rd_wd_dec;

    assign trap       = (state_q == TRAP);
    assign trap_cause = cause_q;
    assign trap_pc    = pc_q;

endmodule
